// File: rtl/uart_pkt_decoder_pkg.sv
// uart_pkt_decoder_pkg: shared state encodings, error codes and default sync byte
package uart_pkt_decoder_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN
  } state_t;
  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_CHECKSUM = 3'd1;
  localparam logic [2:0] ERR_FRAMING  = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_OVERRUN  = 3'd4;
  localparam logic [2:0] ERR_BADLEN   = 3'd5;
  localparam logic [7:0] SYNC_DEF     = 8'hA5;
endpackage

// File: rtl/uart_pkt_buf.sv
// uart_pkt_buf: payload register array, synchronous write, combinational read
module uart_pkt_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] ridx,
  output logic [7:0]    rdata
);
  logic [7:0] mem [MAX_LEN];
  always_ff @(posedge CLK)
    if (we) mem[widx] <= wdata;
  assign rdata = mem[ridx];
endmodule

// File: rtl/uart_pkt_decoder.sv
// uart_pkt_decoder: hunts for sync, validates an addr/len/payload/checksum frame,
// then replays the buffered payload as a burst of register writes.
module uart_pkt_decoder
  import uart_pkt_decoder_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 1200000,
  parameter logic [7:0] SYNC = SYNC_DEF
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  input  logic       framing_error,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       pkt_done,
  output logic       err,
  output logic [2:0] err_code
);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 2);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  state_t state, state_n;
  logic [7:0] idx, idx_n, len, len_n, addr, addr_n, sum, sum_n, rd_idx, rd_data;
  logic [7:0] wr_addr_n, wr_data_n;
  logic [TW-1:0] tmr, tmr_n;
  logic wr_valid_n, pkt_done_n, err_n, buf_we, byte_v, in_frame;
  logic [2:0] err_code_n;
  // CHK primes the first write; during DRAIN we prefetch the next entry
  assign rd_idx = (state == S_CHK) ? 8'd0 : 8'(idx + 8'd1);
  assign byte_v = rx_ready & ~framing_error;
  assign in_frame = state inside {S_ADDR, S_LEN, S_PAYLOAD, S_CHK};
  uart_pkt_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .CLK(CLK), .we(buf_we), .widx(idx[AW-1:0]), .wdata(rx_data),
    .ridx(rd_idx[AW-1:0]), .rdata(rd_data)
  );
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state <= S_IDLE;
      {idx, len, addr, sum, tmr} <= '0;
      {wr_valid, wr_addr, wr_data, pkt_done, err, err_code} <= '0;
    end else begin
      state <= state_n;
      {idx, len, addr, sum, tmr} <= {idx_n, len_n, addr_n, sum_n, tmr_n};
      {wr_valid, wr_addr, wr_data} <= {wr_valid_n, wr_addr_n, wr_data_n};
      {pkt_done, err, err_code} <= {pkt_done_n, err_n, err_code_n};
    end
  end
  always_comb begin
    state_n = state;
    {idx_n, len_n, addr_n, sum_n} = {idx, len, addr, sum};
    tmr_n = in_frame ? (rx_ready ? '0 : tmr + TW'(1)) : '0;
    {wr_valid_n, wr_addr_n, wr_data_n} = {wr_valid, wr_addr, wr_data};
    pkt_done_n = 1'b0;
    err_n = 1'b0;
    err_code_n = ERR_NONE;
    buf_we = 1'b0;
    if (in_frame && framing_error) begin
      state_n = S_IDLE;
      {err_n, err_code_n} = {1'b1, ERR_FRAMING};
    end else if (in_frame && !rx_ready && tmr == TLIM) begin
      state_n = S_IDLE;
      {err_n, err_code_n} = {1'b1, ERR_TIMEOUT};
    end else begin
      unique case (state)
        S_IDLE: state_n = (byte_v && rx_data == SYNC) ? S_ADDR : S_IDLE;
        S_ADDR: if (byte_v) begin
          addr_n = rx_data;
          sum_n = rx_data;
          state_n = S_LEN;
        end
        S_LEN: if (byte_v) begin
          if (rx_data == 8'd0 || rx_data > MAX_B) begin
            state_n = S_IDLE;
            {err_n, err_code_n} = {1'b1, ERR_BADLEN};
          end else begin
            len_n = rx_data;
            idx_n = '0;
            sum_n = 8'(sum + rx_data);
            state_n = S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (byte_v) begin
          buf_we = 1'b1;
          sum_n = 8'(sum + rx_data);
          idx_n = 8'(idx + 8'd1);
          state_n = (8'(idx + 8'd1) == len) ? S_CHK : S_PAYLOAD;
        end
        S_CHK: if (byte_v) begin
          if (8'(sum + rx_data) != 8'd0) begin
            state_n = S_IDLE;
            {err_n, err_code_n} = {1'b1, ERR_CHECKSUM};
          end else begin
            idx_n = '0;
            state_n = S_DRAIN;
            {wr_valid_n, wr_addr_n, wr_data_n} = {1'b1, addr, rd_data};
          end
        end
        S_DRAIN: begin
          if (byte_v) {err_n, err_code_n} = {1'b1, ERR_OVERRUN};
          if (wr_valid && wr_ready) begin
            if (8'(idx + 8'd1) == len) begin
              wr_valid_n = 1'b0;
              pkt_done_n = 1'b1;
              state_n = S_IDLE;
            end else begin
              idx_n = 8'(idx + 8'd1);
              wr_addr_n = 8'(wr_addr + 8'd1);
              wr_data_n = rd_data;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_pkt_decoder.sv
// tb_uart_pkt_decoder: directed scenario tasks with hand-computed expectations
module tb_uart_pkt_decoder;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 20;
  typedef logic [7:0] bq_t[$];
  logic CLK = 0, rst_n = 0, rx_ready = 0, framing_error = 0, wr_ready = 0;
  logic [7:0] rx_data = 0;
  logic wr_valid, pkt_done, err;
  logic [7:0] wr_addr, wr_data;
  logic [2:0] err_code;
  int errors = 0, checks = 0, n_wr = 0, n_err = 0, n_done = 0;
  always #5 CLK = ~CLK;
  uart_pkt_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .SYNC(8'hA5)) dut (
    .CLK(CLK), .rst_n(rst_n), .rx_ready(rx_ready), .rx_data(rx_data),
    .framing_error(framing_error), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .pkt_done(pkt_done), .err(err),
    .err_code(err_code)
  );
  always @(posedge CLK) begin
    if (wr_valid && wr_ready) n_wr <= n_wr + 1;
    if (err) n_err <= n_err + 1;
    if (pkt_done) n_done <= n_done + 1;
  end
  // each byte strobe lasts one cycle; returns at the negedge after it was sampled
  task send_seq(input bq_t q);
    foreach (q[i]) begin
      @(negedge CLK); rx_ready = 1; rx_data = q[i];
      @(negedge CLK); rx_ready = 0;
    end
  endtask
  task send_b2b(input bq_t q);
    foreach (q[i]) begin
      @(negedge CLK); rx_ready = 1; rx_data = q[i];
    end
    @(negedge CLK); rx_ready = 0;
  endtask
  task test_reset;
    rst_n = 0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({wr_valid, wr_addr, wr_data, pkt_done, err, err_code} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b a=%h d=%h done=%b err=%b code=%0d want all 0", wr_valid, wr_addr, wr_data, pkt_done, err, err_code);
    end
    rst_n = 1;
    @(negedge CLK);
  endtask
  task test_good;
    logic [7:0] ea[3], ed[3];
    int e0;
    ea = '{8'h10, 8'h11, 8'h12}; ed = '{8'h11, 8'h22, 8'h33};
    e0 = n_err;
    wr_ready = 1;
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87});
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, ea[i], ed[i]}) begin
        errors++;
        $display("FAIL good_write%0d: got v=%b a=%h d=%h want 1 %h %h", i, wr_valid, wr_addr, wr_data, ea[i], ed[i]);
      end
      @(negedge CLK);
    end
    checks++;
    if ({pkt_done, wr_valid} !== 2'b10) begin
      errors++;
      $display("FAIL good_done: got done=%b v=%b want 1 0", pkt_done, wr_valid);
    end
    @(negedge CLK);
    checks++;
    if (pkt_done !== 1'b0 || n_err != e0) begin
      errors++;
      $display("FAIL good_after: got done=%b errs=%0d want 0 0", pkt_done, n_err - e0);
    end
  endtask
  task test_bad_checksum;
    int w0;
    w0 = n_wr;
    wr_ready = 1;
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88});
    checks++;
    if ({err, err_code, wr_valid} !== {1'b1, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL chk_err: got err=%b code=%0d v=%b want 1 1 0", err, err_code, wr_valid);
    end
    @(negedge CLK);
    checks++;
    if ({err, err_code} !== 4'd0) begin
      errors++;
      $display("FAIL chk_err_pulse: got err=%b code=%0d want 0 0", err, err_code);
    end
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87});
    repeat (6) @(negedge CLK);
    checks++;
    if (n_wr - w0 != 3) begin
      errors++;
      $display("FAIL chk_recover: got writes=%0d want 3", n_wr - w0);
    end
  endtask
  task test_backpressure;
    wr_ready = 0;
    send_seq('{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h9A});
    checks++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'hFF, 8'hAA}) begin
      errors++;
      $display("FAIL bp_first: got v=%b a=%h d=%h want 1 ff aa", wr_valid, wr_addr, wr_data);
    end
    rx_ready = 1; rx_data = 8'h55;
    @(negedge CLK); rx_ready = 0;
    checks++;
    if ({err, err_code, wr_valid, wr_addr, wr_data} !== {1'b1, 3'd4, 1'b1, 8'hFF, 8'hAA}) begin
      errors++;
      $display("FAIL bp_overrun: got err=%b code=%0d v=%b a=%h d=%h want 1 4 1 ff aa", err, err_code, wr_valid, wr_addr, wr_data);
    end
    wr_ready = 1;
    @(negedge CLK); wr_ready = 0;
    checks++;
    if ({err, wr_valid, wr_addr, wr_data} !== {1'b0, 1'b1, 8'h00, 8'hBB}) begin
      errors++;
      $display("FAIL bp_wrap: got err=%b v=%b a=%h d=%h want 0 1 00 bb", err, wr_valid, wr_addr, wr_data);
    end
    @(negedge CLK); wr_ready = 1;
    checks++;
    if ({wr_valid, wr_addr, wr_data, pkt_done} !== {1'b1, 8'h00, 8'hBB, 1'b0}) begin
      errors++;
      $display("FAIL bp_stall: got v=%b a=%h d=%h done=%b want 1 00 bb 0", wr_valid, wr_addr, wr_data, pkt_done);
    end
    @(negedge CLK);
    checks++;
    if ({pkt_done, wr_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_done: got done=%b v=%b want 1 0", pkt_done, wr_valid);
    end
  endtask
  task test_length_framing;
    int w0;
    w0 = n_wr;
    wr_ready = 1;
    send_seq('{8'hA5, 8'h10, 8'h00});
    checks++;
    if ({err, err_code} !== {1'b1, 3'd5}) begin
      errors++;
      $display("FAIL len_zero: got err=%b code=%0d want 1 5", err, err_code);
    end
    send_seq('{8'hA5, 8'h10, 8'(MAX_LEN + 1)});
    checks++;
    if ({err, err_code} !== {1'b1, 3'd5}) begin
      errors++;
      $display("FAIL len_over: got err=%b code=%0d want 1 5", err, err_code);
    end
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11});
    framing_error = 1;
    @(negedge CLK); framing_error = 0;
    checks++;
    if ({err, err_code} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL frm_payload: got err=%b code=%0d want 1 2", err, err_code);
    end
    send_seq('{8'h22, 8'h33, 8'h87});
    send_seq('{8'hA5, 8'h10});
    rx_ready = 1; rx_data = 8'h03; framing_error = 1;
    @(negedge CLK); rx_ready = 0; framing_error = 0;
    checks++;
    if ({err, err_code} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL frm_coincident: got err=%b code=%0d want 1 2", err, err_code);
    end
    send_seq('{8'h03, 8'h11, 8'h22, 8'h33, 8'h87});
    repeat (6) @(negedge CLK);
    checks++;
    if (n_wr != w0) begin
      errors++;
      $display("FAIL aborted_writes: got writes=%0d want 0", n_wr - w0);
    end
  endtask
  task test_timeout;
    logic early;
    int e0;
    early = 0;
    send_seq('{8'hA5, 8'h10});
    for (int k = 1; k <= TIMEOUT - 2; k++) begin
      @(negedge CLK);
      if (err) early = 1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: got early_err=%b want 0", early);
    end
    @(negedge CLK);
    checks++;
    if ({err, err_code} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL tmo_fire: got err=%b code=%0d want 1 3", err, err_code);
    end
    @(negedge CLK);
    e0 = n_err;
    send_seq('{8'h00, 8'hFF, 8'h5A});
    repeat (TIMEOUT + 5) @(negedge CLK);
    checks++;
    if (n_err != e0 || wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_garbage: got errs=%0d v=%b want 0 0", n_err - e0, wr_valid);
    end
  endtask
  task test_back_to_back;
    bq_t q;
    int w0;
    w0 = n_wr;
    wr_ready = 1;
    send_b2b('{8'hA5, 8'h30, 8'h01, 8'h7F, 8'h50});
    checks++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h30, 8'h7F}) begin
      errors++;
      $display("FAIL b2b_write: got v=%b a=%h d=%h want 1 30 7f", wr_valid, wr_addr, wr_data);
    end
    q = '{8'hA5, 8'h40, 8'(MAX_LEN)};
    for (int i = 0; i < MAX_LEN; i++) q.push_back(8'(i));
    q.push_back(8'h38);
    send_b2b(q);
    checks++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h40, 8'h00}) begin
      errors++;
      $display("FAIL maxlen_first: got v=%b a=%h d=%h want 1 40 00", wr_valid, wr_addr, wr_data);
    end
    repeat (MAX_LEN + 3) @(negedge CLK);
    checks++;
    if (n_wr - w0 != MAX_LEN + 1) begin
      errors++;
      $display("FAIL maxlen_count: got writes=%0d want %0d", n_wr - w0, MAX_LEN + 1);
    end
  endtask
  task test_reset_drain;
    int w0, d0;
    wr_ready = 0;
    send_seq('{8'hA5, 8'h20, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hD2});
    checks++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h20, 8'h01}) begin
      errors++;
      $display("FAIL rst_pre: got v=%b a=%h d=%h want 1 20 01", wr_valid, wr_addr, wr_data);
    end
    w0 = n_wr; d0 = n_done;
    rst_n = 0;
    @(negedge CLK);
    checks++;
    if ({wr_valid, wr_addr, wr_data, pkt_done, err, err_code} !== 29'd0) begin
      errors++;
      $display("FAIL rst_drain: got v=%b a=%h d=%h done=%b err=%b code=%0d want all 0", wr_valid, wr_addr, wr_data, pkt_done, err, err_code);
    end
    rst_n = 1; wr_ready = 1;
    repeat (8) @(negedge CLK);
    checks++;
    if (n_wr != w0 || n_done != d0) begin
      errors++;
      $display("FAIL rst_no_done: got writes=%0d dones=%0d want 0 0", n_wr - w0, n_done - d0);
    end
  endtask
  initial begin
    test_reset;
    test_good;
    test_bad_checksum;
    test_backpressure;
    test_length_framing;
    test_timeout;
    test_back_to_back;
    test_reset_drain;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
